vx_icache_mem_responder: RTL and testbench

Instruction-memory responder for the core's icache request/response interface: it is the memory side that answers icache_req_valid/addr/tag and returns icache_rsp_valid/data/tag. It holds a word-addressed instruction store with a preload port, a fixed-latency read pipeline, and a credit-limited response queue that honours icache_rsp_ready backpressure. It is used as a single-core memory model and as a bring-up stand-in for the real icache.

---
 rtl/vx_icache_mem_responder_pkg.sv | 25 ++
 rtl/vx_icache_rsp_queue.sv | 56 +++++
 rtl/vx_icache_mem_responder.sv | 120 ++++++++++++
 tb/tb_vx_icache_mem_responder.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_icache_mem_responder_pkg.sv
// Shared definitions for the icache memory responder: NOP fill word, response
// payload layout and the elaboration-time LATENCY range check.
`ifndef VX_ICACHE_MEM_RESPONDER_PKG_SV
`define VX_ICACHE_MEM_RESPONDER_PKG_SV

`define VX_ICACHE_CHECK_LATENCY(lat) \
   if (((lat) < 2) || ((lat) > 8)) begin : g_bad_latency \
      $error("vx_icache_mem_responder: LATENCY must be in 2..8"); \
   end

package vx_icache_mem_responder_pkg;

   localparam int ICORE_TAG_WIDTH = 8;

   // Returned for addresses beyond the store (addi x0,x0,0).
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [31:0]                data;
      logic [ICORE_TAG_WIDTH-1:0] tag;
   } rsp_payload_t;

endpackage

`endif

// File: rtl/vx_icache_rsp_queue.sv
// Synchronous response FIFO; power-of-2 depth with an extra wrap bit on each
// pointer so full and empty can be told apart without a separate counter.
module vx_icache_rsp_queue
   import vx_icache_mem_responder_pkg::*;
#(
   parameter int WIDTH = 40,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             do_push, do_pop;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

   // A push into a full queue is only taken when the head leaves the same cycle.
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
   end

endmodule

// File: rtl/vx_icache_mem_responder.sv
// Memory side of the icache request/response interface: preloadable word
// store, fixed-latency read pipe and a credit-limited in-order response queue.
module vx_icache_mem_responder
   import vx_icache_mem_responder_pkg::*;
#(
   parameter int CORE_TAG_WIDTH = 8,
   parameter int MEM_ADDR_WIDTH = 10,
   parameter int LATENCY        = 2,
   parameter int RSP_QUEUE_SIZE = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      icache_req_valid,
   input  logic [29:0]               icache_req_addr,
   input  logic [CORE_TAG_WIDTH-1:0] icache_req_tag,
   output logic                      icache_req_ready,
   output logic                      icache_rsp_valid,
   output logic [31:0]               icache_rsp_data,
   output logic [CORE_TAG_WIDTH-1:0] icache_rsp_tag,
   input  logic                      icache_rsp_ready,
   input  logic                      init_valid,
   input  logic [MEM_ADDR_WIDTH-1:0] init_addr,
   input  logic [31:0]               init_data,
   output logic                      busy,
   output logic [31:0]               req_count
);

   localparam int CW   = $clog2(RSP_QUEUE_SIZE) + 1;
   localparam int PW   = 32 + CORE_TAG_WIDTH;
   localparam int NSTG = LATENCY - 1;
   localparam logic [CW-1:0] CREDITS_MAX = CW'(RSP_QUEUE_SIZE);

   `VX_ICACHE_CHECK_LATENCY(LATENCY)

   if ((RSP_QUEUE_SIZE < 2) || ((RSP_QUEUE_SIZE & (RSP_QUEUE_SIZE - 1)) != 0)) begin : g_bad_qsize
      $error("vx_icache_mem_responder: RSP_QUEUE_SIZE must be a power of 2, at least 2");
   end

   logic [31:0]   store_q [2**MEM_ADDR_WIDTH];
   logic [CW-1:0] credits_q, credits_d;
   logic [31:0]   req_count_q, req_count_d;
   logic [NSTG-1:0] stg_valid_q;
   logic [PW-1:0]   stg_pay_q [NSTG];

   logic          req_accept, rsp_consume;
   logic          addr_oob;
   logic [31:0]   rd_data;
   logic          q_push, q_full, q_empty;
   logic [PW-1:0] q_head;

   // Gating with reset keeps ready low while the credit register is held.
   assign icache_req_ready = reset && (credits_q != '0) && !init_valid;
   assign req_accept       = icache_req_valid && icache_req_ready;
   assign rsp_consume      = icache_rsp_valid && icache_rsp_ready;

   assign addr_oob = (icache_req_addr[29:MEM_ADDR_WIDTH] != '0);
   assign rd_data  = addr_oob ? NOP_INSTR : store_q[icache_req_addr[MEM_ADDR_WIDTH-1:0]];

   always_ff @(posedge clk) begin
      if (init_valid) store_q[init_addr] <= init_data;
   end

   always_ff @(posedge clk) begin
      if (req_accept) stg_pay_q[0] <= {rd_data, icache_req_tag};
      for (int i = 1; i < NSTG; i++) begin
         stg_pay_q[i] <= stg_pay_q[i-1];
      end
   end

   always_comb begin
      credits_d   = credits_q;
      req_count_d = req_count_q;
      if (req_accept && !rsp_consume)      credits_d = credits_q - CW'(1);
      else if (!req_accept && rsp_consume) credits_d = credits_q + CW'(1);
      if (req_accept) req_count_d = req_count_q + 32'd1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         credits_q   <= CREDITS_MAX;
         req_count_q <= '0;
         stg_valid_q <= '0;
      end else begin
         credits_q      <= credits_d;
         req_count_q    <= req_count_d;
         stg_valid_q[0] <= req_accept;
         for (int i = 1; i < NSTG; i++) begin
            stg_valid_q[i] <= stg_valid_q[i-1];
         end
      end
   end

   assign q_push = stg_valid_q[NSTG-1];

   vx_icache_rsp_queue #(
      .WIDTH (PW),
      .DEPTH (RSP_QUEUE_SIZE)
   ) u_rsp_queue (
      .clk         (clk),
      .rst_n       (reset),
      .push_i      (q_push),
      .push_data_i (stg_pay_q[NSTG-1]),
      .pop_i       (rsp_consume),
      .head_o      (q_head),
      .full_o      (q_full),
      .empty_o     (q_empty)
   );

   // Credits bound the outstanding count, so a push never meets a full queue
   // unless the head is leaving in the same cycle.
   assert property (@(posedge clk) disable iff (!reset) !(q_push && q_full && !rsp_consume));

   assign icache_rsp_valid = !q_empty;
   assign icache_rsp_data  = icache_rsp_valid ? q_head[PW-1 -: 32] : '0;
   assign icache_rsp_tag   = icache_rsp_valid ? q_head[CORE_TAG_WIDTH-1:0] : '0;

   assign busy      = (credits_q != CREDITS_MAX);
   assign req_count = req_count_q;

endmodule

// File: tb/tb_vx_icache_mem_responder.sv
// Directed bench for vx_icache_mem_responder with a queue scoreboard: accepts
// push the expected {data, tag}, consumed responses pop and compare.
module tb_vx_icache_mem_responder;

   localparam int TW  = 8;
   localparam int AW  = 10;
   localparam int LAT = 2;
   localparam int QS  = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          icache_req_valid = 1'b0;
   logic [29:0]   icache_req_addr = '0;
   logic [TW-1:0] icache_req_tag = '0;
   logic          icache_req_ready;
   logic          icache_rsp_valid;
   logic [31:0]   icache_rsp_data;
   logic [TW-1:0] icache_rsp_tag;
   logic          icache_rsp_ready = 1'b1;
   logic          init_valid = 1'b0;
   logic [AW-1:0] init_addr = '0;
   logic [31:0]   init_data = '0;
   logic          busy;
   logic [31:0]   req_count;

   vx_icache_mem_responder #(
      .CORE_TAG_WIDTH (TW),
      .MEM_ADDR_WIDTH (AW),
      .LATENCY        (LAT),
      .RSP_QUEUE_SIZE (QS)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .icache_req_valid (icache_req_valid),
      .icache_req_addr  (icache_req_addr),
      .icache_req_tag   (icache_req_tag),
      .icache_req_ready (icache_req_ready),
      .icache_rsp_valid (icache_rsp_valid),
      .icache_rsp_data  (icache_rsp_data),
      .icache_rsp_tag   (icache_rsp_tag),
      .icache_rsp_ready (icache_rsp_ready),
      .init_valid       (init_valid),
      .init_addr        (init_addr),
      .init_data        (init_data),
      .busy             (busy),
      .req_count        (req_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0]   data;
      logic [TW-1:0] tag;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        e;
   logic [31:0] tb_mem [0:1023];
   int n_vec = 0, n_err = 0;
   int cyc = 0;
   int n_acc = 0, n_cons = 0, n_rise = 0, rise_cyc = 0;
   logic prev_valid = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic fail(input string name);
      n_vec++;
      n_err++;
      $display("FAIL %s: bound expired or unexpected event (t=%0t)", name, $time);
   endtask

   function automatic logic [31:0] model_rd(input logic [29:0] a);
      if (a[29:10] != 20'd0) return 32'h0000_0013;
      return tb_mem[a[9:0]];
   endfunction

   // Monitor: sampled on the falling edge, between active edges.
   always @(negedge clk) begin
      if (!reset) begin
         exp_q.delete();
         prev_valid = 1'b0;
      end else begin
         if (icache_rsp_valid && !prev_valid) begin
            n_rise++;
            rise_cyc = cyc;
         end
         prev_valid = icache_rsp_valid;
         if (icache_rsp_valid && icache_rsp_ready) begin
            n_cons++;
            if (exp_q.size() == 0) fail("rsp_without_request");
            else begin
               e = exp_q.pop_front();
               check("rsp_data", icache_rsp_data, e.data);
               check("rsp_tag", 32'(icache_rsp_tag), 32'(e.tag));
            end
         end
         if (icache_req_valid && icache_req_ready) begin
            n_acc++;
            exp_q.push_back('{model_rd(icache_req_addr), icache_req_tag});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
      init_valid = 1'b1;
      init_addr  = a;
      init_data  = d;
      tb_mem[a]  = d;
      tick();
      init_valid = 1'b0;
   endtask

   task automatic send(input logic [29:0] a, input logic [TW-1:0] t, output int acc_cyc);
      bit ok;
      int budget;
      budget = 0;
      icache_req_valid = 1'b1;
      icache_req_addr  = a;
      icache_req_tag   = t;
      do begin
         @(negedge clk);
         ok = icache_req_ready;
         acc_cyc = cyc;
         tick();
         budget++;
      end while (!ok && budget < 200);
      if (!ok) fail("send_timeout");
   endtask

   task automatic wait_idle(input string name);
      int b;
      b = 0;
      while ((busy || exp_q.size() != 0) && b < 100) begin
         tick();
         b++;
      end
      if (b >= 100) fail(name);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int a0, dummy, r0, c0, acc0;
      logic [TW-1:0] tg;

      // Reset state
      repeat (2) tick();
      check("rst_req_ready", 32'(icache_req_ready), 0);
      check("rst_rsp_valid", 32'(icache_rsp_valid), 0);
      check("rst_rsp_data", icache_rsp_data, 0);
      check("rst_rsp_tag", 32'(icache_rsp_tag), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_req_count", req_count, 0);

      for (int i = 0; i < 4; i++) preload(AW'(i), 32'hA0 + 32'(i));
      reset = 1'b1;
      tick();
      check("post_rst_req_ready", 32'(icache_req_ready), 1);

      // Back-to-back reads with the consumer always ready
      r0 = n_rise;
      c0 = n_cons;
      send(30'd0, 8'd1, a0);
      send(30'd1, 8'd2, dummy);
      send(30'd2, 8'd3, dummy);
      send(30'd3, 8'd4, dummy);
      icache_req_valid = 1'b0;
      wait_idle("t1_drain");
      check("t1_latency", 32'(rise_cyc - a0), LAT);
      check("t1_one_burst", 32'(n_rise - r0), 1);
      check("t1_consumed", 32'(n_cons - c0), 4);
      check("t1_req_count", req_count, 4);

      // Credit exhaustion under backpressure
      icache_rsp_ready = 1'b0;
      acc0 = n_acc;
      for (int i = 0; i < 6; i++) begin
         icache_req_valid = 1'b1;
         icache_req_addr  = 30'(i % 4);
         icache_req_tag   = 8'h20 + 8'(i);
         tick();
      end
      icache_req_valid = 1'b0;
      check("t2_accepted", 32'(n_acc - acc0), 4);
      check("t2_req_ready", 32'(icache_req_ready), 0);
      check("t2_busy", 32'(busy), 1);
      repeat (3) tick();
      check("t2_stall_valid", 32'(icache_rsp_valid), 1);
      check("t2_stall_tag0", 32'(icache_rsp_tag), 32'h20);
      tick();
      check("t2_stall_tag1", 32'(icache_rsp_tag), 32'h20);
      check("t2_stall_data", icache_rsp_data, 32'hA0);
      icache_rsp_ready = 1'b1;
      wait_idle("t2_drain");
      check("t2_ready_back", 32'(icache_req_ready), 1);
      check("t2_req_count", req_count, 8);

      // Full queue with concurrent pop and accept every cycle
      icache_rsp_ready = 1'b0;
      for (int i = 0; i < 4; i++) send(30'(i), 8'h30 + 8'(i), dummy);
      icache_req_valid = 1'b0;
      repeat (LAT + 1) tick();
      check("t3_full_ready", 32'(icache_req_ready), 0);
      icache_rsp_ready = 1'b1;
      acc0 = n_acc;
      c0   = n_cons;
      tg   = 8'h34;
      icache_req_valid = 1'b1;
      icache_req_addr  = 30'(tg % 4);
      icache_req_tag   = tg;
      for (int i = 0; i < 20; i++) begin
         bit ok;
         @(negedge clk);
         ok = icache_req_ready;
         tick();
         if (ok) begin
            tg = tg + 8'd1;
            icache_req_addr = 30'(tg % 4);
            icache_req_tag  = tg;
         end
      end
      icache_req_valid = 1'b0;
      check("t3_accepts", 32'(n_acc - acc0), 19);
      check("t3_consumes", 32'(n_cons - c0), 20);
      wait_idle("t3_drain");

      // Address beyond the store returns the NOP word
      send(30'h0000_0400, 8'h55, dummy);
      send(30'h2000_0001, 8'h56, dummy);
      icache_req_valid = 1'b0;
      wait_idle("t4_drain");

      // Preload blocks a concurrent request, then the new word is visible
      icache_req_valid = 1'b1;
      icache_req_addr  = 30'd5;
      icache_req_tag   = 8'h60;
      init_valid = 1'b1;
      init_addr  = AW'(5);
      init_data  = 32'hDEAD_BEEF;
      tb_mem[5]  = 32'hDEAD_BEEF;
      @(negedge clk);
      check("t5_ready_during_init", 32'(icache_req_ready), 0);
      tick();
      init_valid = 1'b0;
      send(30'd5, 8'h60, dummy);
      icache_req_valid = 1'b0;
      wait_idle("t5_drain");

      // Reset with requests in flight
      icache_rsp_ready = 1'b0;
      send(30'd0, 8'h70, dummy);
      send(30'd1, 8'h71, dummy);
      send(30'd2, 8'h72, dummy);
      icache_req_valid = 1'b0;
      check("t6_valid_before_rst", 32'(icache_rsp_valid), 1);
      reset = 1'b0;
      #1;
      check("t6_rsp_valid_rst", 32'(icache_rsp_valid), 0);
      check("t6_busy_rst", 32'(busy), 0);
      check("t6_req_count_rst", req_count, 0);
      repeat (2) tick();
      reset = 1'b1;
      tick();
      check("t6_busy_after", 32'(busy), 0);
      check("t6_req_count_after", req_count, 0);
      check("t6_ready_after", 32'(icache_req_ready), 1);
      icache_rsp_ready = 1'b1;
      c0 = n_cons;
      send(30'd2, 8'h80, dummy);
      icache_req_valid = 1'b0;
      wait_idle("t6_drain");
      check("t6_one_rsp", 32'(n_cons - c0), 1);
      check("t6_req_count_end", req_count, 1);

      check("sb_empty", 32'(exp_q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
